// File: rtl/fp_mult_pkg.sv
// Shared types and helpers for the FP multiplier issue stage.
// Operand classification feeds the mantissa multiplier control.
package fp_mult_pkg;

  localparam int ITER_DEF = 24;
  localparam int EXP_W = 8;
  localparam int MANT_W = 23;
  localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  typedef struct packed {
    logic           bypass;
    logic           sign;
    logic [EXP_W:0] exp_sum;
  } fp_attr_t;

  // -0 counts as zero since bit 31 is ignored
  function automatic fp_attr_t fp_attr(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic za;
    logic zb;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    fp_attr_t r;
    za = (a[30:0] == 31'd0);
    zb = (b[30:0] == 31'd0);
    ea = a[MANT_W+EXP_W-1:MANT_W];
    eb = b[MANT_W+EXP_W-1:MANT_W];
    r.bypass = za | zb | (ea == EXP_ALL_ONES)
             | (eb == EXP_ALL_ONES);
    r.sign = !(za | zb) & (a[31] ^ b[31]);
    r.exp_sum = (za | zb) ? '0
              : {1'b0, ea} + {1'b0, eb};
    return r;
  endfunction

endpackage

// File: rtl/fp_mult_issue_fifo.sv
// Two-entry operand pair buffer ({a, b} packed as 64 bits).
// Pointer based; head is always visible on dout.
module operand_fifo2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [63:0] din,
  output logic [63:0] dout,
  output logic [1:0]  count,
  output logic        full,
  output logic        empty
);

  logic [63:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push}
                     - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fp_mult_issue.sv
// Issue stage for the Booth mantissa multiplier: buffers operand
// pairs, classifies them, and sequences LOAD/RUN/DONE.
module fp_mult_issue
  import fp_mult_pkg::*;
#(
  parameter int ITER  = ITER_DEF,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        mult_load,
  output logic        sign,
  output logic [8:0]  exp_sum,
  output logic        bypass,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(ITER + 1);

  state_e      state;
  logic [CW-1:0] cnt;
  logic [1:0]  count;
  logic        full;
  logic        empty;
  logic [63:0] head;
  logic        push;
  logic        pop;
  fp_attr_t    attr;

  assign in_ready = !reset && !full
                 && (count < 2'(DEPTH));
  assign push = in_valid && in_ready;
  assign pop  = !reset && !empty
             && (state == IDLE || state == DONE);
  assign attr = fp_attr(head[63:32], head[31:0]);

  assign mult_load = reset || (state == LOAD);
  assign busy      = !reset && (state != IDLE);
  assign done      = !reset && (state == DONE);

  operand_fifo2 u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   ({in_a, in_b}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      sign    <= 1'b0;
      exp_sum <= '0;
      bypass  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (pop) begin
            state   <= LOAD;
            op_a    <= head[63:32];
            op_b    <= head[31:0];
            sign    <= attr.sign;
            exp_sum <= attr.exp_sum;
            bypass  <= attr.bypass;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= bypass ? DONE : RUN;
        end
        RUN: begin
          if (cnt == CW'(ITER - 1)) state <= DONE;
          else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
